// File: rtl/cntb_ex_stage_multi.sv
// -----------------------------------------------------------------------------
// cntb_ex_stage_multi
//
// Purpose:
//   CNTB custom-instruction execute stage on the X-interface issue path.
//   Takes rs0 and a start position (rs1). It counts the run of consecutive
//   bits that equal rs0[pos], walking either toward bit 0 (funct3=000) or
//   toward the MSB (funct3=001). CHUNK bits are examined per EXEC cycle.
//   The run length (1..XLEN) is returned through a valid/ready handshake
//   together with the destination register address instr[11:7].
//
// Configuration macro:
//   CNTB_WRAP_EN - when defined, the scan wraps circularly around the operand.
//                  The only limit is then the total count reaching XLEN.
//                  When undefined, the scan stops hard at bit 0 (down) or
//                  bit XLEN-1 (up), and no wrap logic is built.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous reset, active-high
//   issue_valid_i   issue request valid
//   issue_ready_o   stage can take an issue (registered)
//   instr_i         offloaded instruction word
//   rs0_i           operand to scan
//   rs1_i           start position, only [$clog2(XLEN)-1:0] used
//   accept_o        instruction recognised (combinational)
//   writeback_o     instruction writes rd (combinational)
//   result_valid_o  result available (registered)
//   result_ready_i  consumer takes result
//   rd_o            run length, zero-extended (registered)
//   rd_addr_o       destination register instr[11:7] (registered)
// -----------------------------------------------------------------------------
module cntb_ex_stage_multi #(
    parameter int         XLEN   = 32,
    parameter int         CHUNK  = 8,
    parameter logic [6:0] OPCODE = 7'h0B
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs0_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic            accept_o,
    output logic            writeback_o,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] rd_o,
    output logic [4:0]      rd_addr_o
);

    localparam int LW = $clog2(XLEN);   // bit-position width
    localparam int CW = LW + 1;         // count width, holds 0..XLEN

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] rs0_r;
    logic [LW-1:0]   ptr_r;
    logic            pol_r;
    logic            dir_r;              // 1 = up toward MSB, 0 = down toward bit 0
    logic [CW-1:0]   count_r;
    logic [XLEN-1:0] rd_r;
    logic [4:0]      rd_addr_r;
    logic            issue_ready_r;
    logic            result_valid_r;

    logic [2:0]      funct3_s;
    logic            decode_hit_s;
    logic [LW-1:0]   start_pos_s;
    logic [CW-1:0]   remain_s;
    logic [CW-1:0]   avail_s;
    logic [CW-1:0]   match_cnt_s;
    logic            chunk_full_s;
    logic            exec_last_s;
    logic [CW-1:0]   count_next_s;
    logic [LW-1:0]   ptr_step_s;
    logic            unused_s;

    assign funct3_s     = instr_i[14:12];
    assign decode_hit_s = (instr_i[6:0] == OPCODE) &&
                          ((funct3_s == 3'b000) || (funct3_s == 3'b001));
    assign start_pos_s  = rs1_i[LW-1:0];
    assign accept_o     = issue_valid_i & decode_hit_s;
    assign writeback_o  = issue_valid_i & decode_hit_s;
    assign unused_s     = ^{instr_i[31:15], rs1_i[XLEN-1:LW]};

    // Bits still eligible for counting before the scan limit.
    always_comb begin
        remain_s = '0;
`ifdef CNTB_WRAP_EN
        remain_s = CW'(XLEN) - count_r;
`else
        if (dir_r) begin
            remain_s = CW'(XLEN) - {1'b0, ptr_r};
        end else begin
            remain_s = {1'b0, ptr_r} + CW'(1);
        end
`endif
    end

    // Number of bits examined this cycle: a full chunk or whatever is left.
    always_comb begin
        if (remain_s < CW'(CHUNK)) begin
            avail_s = remain_s;
        end else begin
            avail_s = CW'(CHUNK);
        end
    end

    // Leading-match count over the current chunk. Pointer arithmetic is
    // modulo XLEN; in no-wrap builds avail_s keeps it inside the operand.
    always_comb begin
        logic          run_v;
        logic [LW-1:0] idx_v;
        match_cnt_s = '0;
        run_v       = 1'b1;
        idx_v       = ptr_r;
        for (int i = 0; i < CHUNK; i++) begin
            if (dir_r) begin
                idx_v = ptr_r + LW'(i);
            end else begin
                idx_v = ptr_r - LW'(i);
            end
            if (run_v && (CW'(i) < avail_s) && (rs0_r[idx_v] == pol_r)) begin
                match_cnt_s = match_cnt_s + CW'(1);
            end else begin
                run_v = 1'b0;
            end
        end
    end

    // The scan ends on the first mismatch, or when the chunk consumed the last
    // eligible bit.
    assign chunk_full_s = (match_cnt_s == avail_s);
    assign exec_last_s  = !chunk_full_s || (avail_s == remain_s);
    assign count_next_s = count_r + match_cnt_s;
    assign ptr_step_s   = dir_r ? (ptr_r + LW'(CHUNK)) : (ptr_r - LW'(CHUNK));

    // Control FSM together with the operand latch and the registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r        <= ST_IDLE;
            rs0_r          <= '0;
            ptr_r          <= '0;
            pol_r          <= 1'b0;
            dir_r          <= 1'b0;
            count_r        <= '0;
            rd_r           <= '0;
            rd_addr_r      <= 5'd0;
            issue_ready_r  <= 1'b1;
            result_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_valid_i && issue_ready_r && decode_hit_s) begin
                        rs0_r         <= rs0_i;
                        ptr_r         <= start_pos_s;
                        pol_r         <= rs0_i[start_pos_s];
                        dir_r         <= funct3_s[0];
                        rd_addr_r     <= instr_i[11:7];
                        count_r       <= '0;
                        issue_ready_r <= 1'b0;
                        state_r       <= ST_EXEC;
                    end else begin
                        issue_ready_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    count_r <= count_next_s;
                    if (exec_last_s) begin
                        rd_r           <= XLEN'(count_next_s);
                        result_valid_r <= 1'b1;
                        state_r        <= ST_DONE;
                    end else begin
                        ptr_r <= ptr_step_s;
                    end
                end
                ST_DONE: begin
                    if (result_ready_i) begin
                        result_valid_r <= 1'b0;
                        issue_ready_r  <= 1'b1;
                        state_r        <= ST_IDLE;
                    end else begin
                        result_valid_r <= 1'b1;
                    end
                end
                default: begin
                    result_valid_r <= 1'b0;
                    issue_ready_r  <= 1'b1;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign issue_ready_o  = issue_ready_r;
    assign result_valid_o = result_valid_r;
    assign rd_o           = rd_r;
    assign rd_addr_o      = rd_addr_r;

endmodule

// File: tb/tb_cntb_ex_stage_multi.sv
// -----------------------------------------------------------------------------
// tb_cntb_ex_stage_multi
//
// Scoreboard bench for cntb_ex_stage_multi (XLEN=32, CHUNK=8). The issuing
// side pushes the expected run length, destination and EXEC-cycle count. It
// gets them from a bit-walking reference model. A separate monitor compares
// each result when result_valid_o rises. It pops the entry when the result
// has been taken. Honours CNTB_WRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_cntb_ex_stage_multi;

    localparam int         XLEN  = 32;
    localparam int         CHUNK = 8;
    localparam logic [6:0] OPC   = 7'h0B;
`ifdef CNTB_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rd;
        logic [4:0]  addr;
        int          cyc;
        int          fire;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs0_i;
    logic [31:0] rs1_i;
    logic        accept_o;
    logic        writeback_o;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] rd_o;
    logic [4:0]  rd_addr_o;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          rr_random = 1'b0;
    bit          rr_level  = 1'b1;

    cntb_ex_stage_multi #(.XLEN(XLEN), .CHUNK(CHUNK), .OPCODE(OPC)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .instr_i        (instr_i),
        .rs0_i          (rs0_i),
        .rs1_i          (rs1_i),
        .accept_o       (accept_o),
        .writeback_o    (writeback_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .rd_o           (rd_o),
        .rd_addr_o      (rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: walk bit by bit from pos, counting bits equal to the start bit.
    function automatic void ref_model(input logic [31:0] v, input int pos, input bit up,
                                      output int len, output int ncyc);
        bit p;
        int idx;
        bit bound;
        p     = v[pos];
        idx   = pos;
        bound = 1'b0;
        len   = 0;
        while (len < XLEN) begin
            if (v[idx] != p) break;
            len++;
            idx = up ? idx + 1 : idx - 1;
            if (idx < 0 || idx > XLEN - 1) begin
                if (WRAP) begin
                    idx = (idx + XLEN) % XLEN;
                end else begin
                    bound = 1'b1;
                    break;
                end
            end
        end
        if (len == XLEN) bound = 1'b1;
        ncyc = bound ? (len + CHUNK - 1) / CHUNK : len / CHUNK + 1;
    endfunction

    // Consumer ready: either a fixed level or random back-pressure.
    initial begin
        result_ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            result_ready_i = rr_random ? 1'($urandom_range(1, 0)) : rr_level;
        end
    end

    // Monitor: check each result when it first appears, hold-check it, and pop
    // it once the result has been taken.
    bit          in_valid = 1'b0;
    logic [31:0] held_rd;
    always @(negedge clk_i) begin
        if (rst_i) begin
            in_valid = 1'b0;
        end else if (result_valid_o && !in_valid) begin
            in_valid = 1'b1;
            held_rd  = rd_o;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(result_valid_o), 32'd0);
            end else begin
                check("rd_o", rd_o, exp_q[0].rd);
                check("rd_addr_o", 32'(rd_addr_o), 32'(exp_q[0].addr));
                check("exec_latency", 32'(cyc - exp_q[0].fire), 32'(exp_q[0].cyc + 1));
            end
        end else if (result_valid_o) begin
            check("rd_stable", rd_o, held_rd);
        end else if (in_valid) begin
            in_valid = 1'b0;
            if (exp_q.size() > 0) exp_q.delete(0);
        end
    end

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                             input logic [6:0] opc);
        logic [16:0] hi;
        hi = 17'($urandom);
        return {hi, f3, rd, opc};
    endfunction

    // Issue one CNTB op. Wait for acceptance, then push the expected result.
    task automatic do_issue(input logic [31:0] v, input logic [31:0] r1, input logic [2:0] f3);
        exp_t e;
        int   len;
        int   ncyc;
        bit   fired;
        logic [4:0] rd;
        rd = 5'($urandom_range(31, 0));
        ref_model(v, int'(r1[4:0]), f3[0], len, ncyc);
        e.rd   = 32'(len);
        e.addr = rd;
        e.cyc  = ncyc;
        fired  = 1'b0;
        @(negedge clk_i);
        issue_valid_i = 1'b1;
        instr_i       = mk_instr(f3, rd, OPC);
        rs0_i         = v;
        rs1_i         = r1;
        #1;
        for (int t = 0; t < 300; t++) begin
            if (issue_ready_o && accept_o) begin
                fired  = 1'b1;
                e.fire = cyc;
                exp_q.push_back(e);
                break;
            end
            @(negedge clk_i);
            #1;
        end
        check("issue_accepted", 32'(fired), 32'd1);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        instr_i       = $urandom;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !result_valid_o) break;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] d_rs0 [7] = '{32'h000000F0, 32'h000000F0, 32'h00000F00, 32'hFF000000,
                               32'hFFFFFFFF, 32'h80000001, 32'hFFFFFFFF};
    logic [31:0] d_rs1 [7] = '{32'd7, 32'd3, 32'd8, 32'd31, 32'd31, 32'd0, 32'd5};
    logic [2:0]  d_f3  [7] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};

    initial begin
        int          len1;
        int          ncyc1;
        logic [31:0] v;
        logic [31:0] hi_mask;
        rst_i         = 1'b1;
        issue_valid_i = 1'b0;
        instr_i       = 32'd0;
        rs0_i         = 32'd0;
        rs1_i         = 32'd0;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_result_valid", 32'(result_valid_o), 32'd0);
        check("rst_rd", rd_o, 32'd0);
        check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_issue_ready", 32'(issue_ready_o), 32'd1);

        // Directed cases.
        for (int i = 0; i < 7; i++) begin
            do_issue(d_rs0[i], d_rs1[i], d_f3[i]);
            wait_idle();
        end

        // Back-pressure: hold ready low while a second request waits.
        rr_level = 1'b0;
        do_issue(32'h0000FF00, 32'd15, 3'b000);
        ref_model(32'h0000FF00, 15, 1'b0, len1, ncyc1);
        for (int t = 0; t < 50; t++) begin
            if (result_valid_o) break;
            @(negedge clk_i);
        end
        @(negedge clk_i);
        issue_valid_i = 1'b1;
        instr_i       = mk_instr(3'b001, 5'd9, OPC);
        rs0_i         = 32'h0000000F;
        rs1_i         = 32'd0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk_i);
            #1;
            check("hold_valid", 32'(result_valid_o), 32'd1);
            check("hold_rd", rd_o, 32'(len1));
            check("hold_issue_ready", 32'(issue_ready_o), 32'd0);
        end
        rr_level = 1'b1;
        do_issue(32'h0000000F, 32'd0, 3'b001);
        wait_idle();

        // Reset during EXEC aborts the op.
        do_issue(32'hFFFFFFFF, 32'd31, 3'b000);
        rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk_i);
        check("mid_rst_valid", 32'(result_valid_o), 32'd0);
        check("mid_rst_rd", rd_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_issue_ready", 32'(issue_ready_o), 32'd1);
        repeat (6) @(negedge clk_i);
        check("mid_rst_no_result", 32'(result_valid_o), 32'd0);

        // Unsupported funct3 and wrong opcode are ignored.
        @(negedge clk_i);
        issue_valid_i = 1'b1;
        instr_i       = mk_instr(3'b010, 5'd3, OPC);
        rs0_i         = $urandom;
        rs1_i         = 32'd4;
        #1;
        check("f3_010_accept", 32'(accept_o), 32'd0);
        check("f3_010_writeback", 32'(writeback_o), 32'd0);
        repeat (4) @(negedge clk_i);
        #1;
        check("f3_010_idle", 32'(issue_ready_o), 32'd1);
        instr_i = mk_instr(3'b000, 5'd3, 7'h33);
        #1;
        check("bad_opcode_accept", 32'(accept_o), 32'd0);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("ignored_no_result", 32'(result_valid_o), 32'd0);

        // Randomised operations with random back-pressure.
        rr_random = 1'b1;
        for (int n = 0; n < 60; n++) begin
            hi_mask = 32'hFFFFFFFF;
            case ($urandom_range(3, 0))
                0: v = $urandom;
                1: v = 32'hFFFFFFFF;
                2: v = 32'h00000000;
                default: v = hi_mask << $urandom_range(31, 0);
            endcase
            if ($urandom_range(1, 0) == 1) v = ~v;
            do_issue(v, $urandom, 3'($urandom_range(1, 0)));
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cntb_ex_stage_multi.md
Name: cntb_ex_stage_multi

Overview:
Parametrised successor of the CNTB custom-instruction execute stage on the X-interface issue path of the core. Counts the run of consecutive bits equal to rs0[pos], starting at bit pos = rs1 and walking toward bit 0 or toward the MSB. Examines CHUNK bits per cycle and returns the run length plus destination register through a valid/ready result handshake. Supports direction select and an optional circular (wrap-around) mode.

Parameters:
XLEN, 32, operand/result width; power of two, >= 8
CHUNK, 8, bits examined per EXEC cycle; power of two, 1..XLEN
OPCODE, 7'h0B, instr[6:0] value decoded as CNTB

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
issue_valid_i  in  1  issue request valid
issue_ready_o  out  1  stage can take an issue
instr_i  in  32  offloaded instruction word
rs0_i  in  XLEN  operand to scan
rs1_i  in  XLEN  start position; only [$clog2(XLEN)-1:0] used
accept_o  out  1  instruction recognised (combinational)
writeback_o  out  1  instruction writes rd (combinational)
result_valid_o  out  1  result available
result_ready_i  in  1  consumer takes result
rd_o  out  XLEN  run length, zero-extended
rd_addr_o  out  5  destination register, instr[11:7]

Behaviour:
- Reset: FSM to IDLE; issue_ready_o=1 after reset release; result_valid_o=0, rd_o=0, rd_addr_o=0; internal count/pointer cleared. Reset mid-operation aborts the op; no result is produced.
- Decode: instr[6:0]==OPCODE and funct3=instr[14:12] in {000 = down toward bit 0, 001 = up toward MSB}.
- accept_o = writeback_o = issue_valid_i & decode-hit. Both 0 when decode misses or funct3 is unsupported.
- FSM IDLE: issue_ready_o=1. Fire = issue_valid_i & issue_ready_o & decode-hit. On fire, latch rs0, pos, polarity p=rs0[pos], direction, rd_addr. Clear count, go EXEC. A non-hit valid is ignored and the FSM stays in IDLE.
- FSM EXEC: issue_ready_o=0. Each cycle compare the next up to CHUNK bits from the current pointer against p.
  - If all match and no boundary is reached: count += CHUNK, advance the pointer, stay in EXEC.
  - Else: count += number of leading matches (plus remaining bits up to the boundary, if all match), then go DONE.
- Boundary: without wrap, bit 0 (down) or bit XLEN-1 (up). The start bit is always counted, so the result is in 1..XLEN.
- Width rule: the count register is $clog2(XLEN)+1 bits and never exceeds XLEN.
- EXEC cycles for run length L: floor(L/CHUNK)+1, except when the run reaches the boundary, where it is ceil(L/CHUNK).
- FSM DONE: result_valid_o=1, rd_o/rd_addr_o stable. On result_ready_i, go IDLE next cycle. While ready is low, hold indefinitely with outputs unchanged.
- Result timing: first result_valid_o is one cycle after the last EXEC cycle. The earliest re-issue is the cycle after the result handshake.
- Simultaneous events: issue_valid_i during EXEC or DONE is not accepted (issue_ready_o=0). The requester must hold it.

Optional Feature:
CNTB_WRAP_EN
- Defined: scanning wraps circularly (down: bit 0 -> bit XLEN-1; up: bit XLEN-1 -> bit 0).
  - The only boundary is the total count reaching XLEN, which saturates at XLEN.
  - EXEC cycle count is floor(L/CHUNK)+1, or XLEN/CHUNK when L=XLEN.
- Undefined: hard boundary as above. The wrap logic is absent from the netlist.

Test Plan:
- XLEN=32, CHUNK=8, rs0=0x000000F0, rs1=7, funct3=000 -> 1 EXEC cycle, rd_o=4, rd_addr_o=instr[11:7].
- rs0=0x000000F0, rs1=3, down -> zero run to bit 0, rd_o=4, 1 EXEC cycle. rs0=0x00000F00, rs1=8, up -> rd_o=4.
- rs0=0xFF000000, rs1=31, down -> 2 EXEC cycles, rd_o=8. rs0=0xFFFFFFFF, rs1=31, down -> 4 EXEC cycles, rd_o=32.
- rs0=0x80000001, rs1=0, down -> rd_o=1 without CNTB_WRAP_EN, rd_o=2 with it. rs0=0xFFFFFFFF, rs1=5, up, wrap -> rd_o=32 after 4 cycles.
- Hold result_ready_i=0 for 5 cycles with issue_valid_i high -> result_valid_o and rd_o stable, issue_ready_o=0, no second accept. Release -> IDLE, then the second op is accepted.
- Assert rst_i during EXEC -> result_valid_o=0, rd_o=0, issue_ready_o=1 after release. Unsupported funct3=010 -> accept_o=0, writeback_o=0, FSM stays in IDLE.
